// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode OP/OP-IMM/LUI/AUIPC into an ALU bundle behind a registered skid buffer
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  shamt,
  output logic        use_shamt,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        illegal
);
  logic [86:0] dec, m_data, s_data;
  logic m_valid, s_valid, acc;
  logic [6:0] op, f7, d_f7;
  logic [2:0] f3, d_f3;
  logic is_op, is_imm, is_lui, is_aui, shift, legal;
  logic [31:0] d_in1, d_in2;
  logic [4:0] d_shamt;
  always_comb begin
    op = instr[6:0];
    f3 = instr[14:12];
    f7 = instr[31:25];
    is_op = op == 7'b0110011;
    is_imm = op == 7'b0010011;
    is_lui = op == 7'b0110111;
    is_aui = op == 7'b0010111;
    shift = (is_op || is_imm) && f3[1:0] == 2'b01;
    legal = is_lui || is_aui
      || (is_op && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
      || (is_imm && (f3 != 3'd1 || f7 == 7'h00) && (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20));
    d_in1 = !legal ? 32'd0 : (is_op || is_imm) ? rs1_data : is_aui ? pc : 32'd0;
    d_in2 = !legal ? 32'd0 : is_op ? rs2_data
      : is_imm ? {{20{instr[31]}}, instr[31:20]} : {instr[31:12], 12'd0};
    d_shamt = (!legal || !shift) ? 5'd0 : is_op ? rs2_data[4:0] : instr[24:20];
    d_f3 = (legal && (is_op || is_imm)) ? f3 : 3'd0;
    // immediate forms only carry funct7 for SRLI/SRAI; everything else is forced to zero
    d_f7 = !legal ? 7'd0 : (is_op || (is_imm && f3 == 3'd5)) ? f7 : 7'd0;
    dec = {d_in1, d_in2, d_shamt, legal && shift, d_f3, d_f7, instr[11:7],
           legal && instr[11:7] != 5'd0, !legal};
  end
  assign acc = in_valid && !s_valid && !flush;
  assign in_ready = !s_valid;
  assign out_valid = m_valid;
  assign {in1, in2, shamt, use_shamt, funct3, funct7, rd, rd_we, illegal} = m_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data <= '0;
      s_data <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || out_ready) begin
      if (s_valid) begin
        m_data <= s_data;
        s_valid <= 1'b0;
      end else begin
        m_valid <= acc;
        if (acc) m_data <= dec;
      end
    end else if (acc) begin
      s_valid <= 1'b1;
      s_data <= dec;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus against a queue-based reference model
module tb_alu_issue_stage;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] instr = 0, pc = 0, rs1_data = 0, rs2_data = 0;
  logic in_ready, out_valid, use_shamt, rd_we, illegal;
  logic [31:0] in1, in2;
  logic [4:0] shamt, rd;
  logic [2:0] funct3;
  logic [6:0] funct7;
  int checks = 0, failures = 0;
  logic [86:0] q[$];

  alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .in1(in1), .in2(in2), .shamt(shamt),
    .use_shamt(use_shamt), .funct3(funct3), .funct7(funct7), .rd(rd), .rd_we(rd_we),
    .illegal(illegal));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [86:0] got, input logic [86:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [86:0] model_dec(input logic [31:0] i, p, a, b);
    logic [31:0] o1, o2;
    logic [4:0] sa;
    logic us, ok;
    logic [2:0] f3;
    logic [6:0] f7;
    o1 = 0; o2 = 0; sa = 0; us = 0; f3 = 0; f7 = 0; ok = 0;
    case (i[6:0])
      7'b0110011: begin
        ok = (i[31:25] == 0) || (i[31:25] == 7'h20 && (i[14:12] == 0 || i[14:12] == 5));
        o1 = a; o2 = b; f3 = i[14:12]; f7 = i[31:25];
        if (f3 == 1 || f3 == 5) begin us = 1; sa = b[4:0]; end
      end
      7'b0010011: begin
        f3 = i[14:12];
        o1 = a; o2 = {{20{i[31]}}, i[31:20]};
        if (f3 == 1) ok = i[31:25] == 0;
        else if (f3 == 5) ok = i[31:25] == 0 || i[31:25] == 7'h20;
        else ok = 1;
        if (f3 == 5) f7 = i[31:25];
        if (f3 == 1 || f3 == 5) begin us = 1; sa = i[24:20]; end
      end
      7'b0110111: begin ok = 1; o2 = {i[31:12], 12'd0}; end
      7'b0010111: begin ok = 1; o1 = p; o2 = {i[31:12], 12'd0}; end
      default: ok = 0;
    endcase
    if (!ok) return {64'd0, 5'd0, 1'b0, 3'd0, 7'd0, i[11:7], 1'b0, 1'b1};
    return {o1, o2, sa, us, f3, f7, i[11:7], i[11:7] != 0, 1'b0};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, q.size() > 0);
    chk({tag, "_in_ready"}, in_ready, q.size() < 2);
    if (q.size() > 0)
      chk({tag, "_bundle"}, {in1, in2, shamt, use_shamt, funct3, funct7, rd, rd_we, illegal}, q[0]);
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] i, p, a, b,
                      input logic ordy, input logic fl);
    int pre;
    in_valid = v; instr = i; pc = p; rs1_data = a; rs2_data = b; out_ready = ordy; flush = fl;
    pre = q.size();
    if (fl) q.delete();
    else begin
      if (pre > 0 && ordy) void'(q.pop_front());
      if (v && pre < 2) q.push_back(model_dec(i, p, a, b));
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] ops[5];
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'h00};
    r = $urandom;
    r[6:0] = (($urandom % 5) == 4) ? 7'($urandom) : ops[$urandom % 4];
    case ($urandom % 3)
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  localparam logic [31:0] ADDI = 32'hFFF08093;

  initial begin
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_data", {in1, in2, shamt, use_shamt, funct3, funct7, rd, rd_we, illegal}, 0);
    @(negedge clk);
    rst_n = 1;
    step("idle", 0, 0, 0, 0, 0, 1, 0);
    step("addi", 1, ADDI, 32'h100, 5, 7, 1, 0);
    chk("addi_in1", in1, 5);
    chk("addi_in2", in2, 32'hFFFFFFFF);
    chk("addi_ctl", {funct3, funct7, use_shamt, rd, rd_we}, {3'd0, 7'd0, 1'b0, 5'd1, 1'b1});
    step("srai", 1, 32'h4041D113, 0, 32'h80000000, 0, 1, 0);
    chk("srai_ctl", {funct3, funct7, use_shamt, shamt, rd}, {3'd5, 7'h20, 1'b1, 5'd4, 5'd2});
    step("mul", 1, 32'h02208033, 0, 9, 9, 1, 0);
    chk("mul_ill", {out_valid, illegal, rd_we, funct7, in1, in2}, {1'b1, 1'b1, 1'b0, 7'd0, 64'd0});
    step("drain", 0, 0, 0, 0, 0, 1, 0);
    step("bp1", 1, ADDI | (32'd1 << 7), 0, 1, 0, 0, 0);
    step("bp2", 1, ADDI | (32'd2 << 7), 0, 2, 0, 0, 0);
    chk("bp_in_ready_low", in_ready, 0);
    step("bp3", 1, ADDI | (32'd3 << 7), 0, 3, 0, 0, 0);
    chk("bp_first_rd", rd, 5'd1);
    for (int k = 0; k < 4; k++) step("bp_rel", 1, ADDI | (32'd3 << 7), 0, 3, 0, 1, 0);
    for (int k = 0; k < 2; k++) step("bp_drain", 0, 0, 0, 0, 0, 1, 0);
    step("fl_a", 1, ADDI, 0, 10, 0, 0, 0);
    step("fl_b", 1, ADDI, 0, 11, 0, 0, 0);
    step("flush", 1, ADDI, 0, 12, 0, 0, 1);
    chk("flush_empty", {out_valid, in_ready}, 2'b01);
    for (int k = 0; k < 2; k++) step("post_flush", 0, 0, 0, 0, 0, 1, 0);
    step("rs_a", 1, ADDI, 0, 20, 0, 0, 0);
    step("rs_b", 1, ADDI, 0, 21, 0, 0, 0);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_rst", {out_valid, in_ready}, 2'b01);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    check_outputs("after_rst");
    for (int k = 0; k < 2000; k++)
      step("rand", ($urandom % 4) != 0, rand_instr(), $urandom, $urandom, $urandom,
           ($urandom % 3) != 0, ($urandom % 25) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
